// File: rtl/load_store_unit_pkg.sv
// Shared types and funct3 size codes for the load/store unit.
// LSU_MISALIGN_TRAP_EN (see load_store_unit.sv) selects misaligned-access trapping.
package load_store_unit_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } lsu_state_t;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;

    function automatic logic size_legal(input logic write, input logic [2:0] size);
        if (write) begin
            return size inside {SB, SH, SW};
        end
        return size inside {LB, LH, LW, LBU, LHU};
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-enable generation, store lane replication and load extract/extend.
// Purely combinational; driven from the latched request fields.
module lsu_align (
    input  logic [2:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] st_data,
    input  logic [31:0] ld_word,
    output logic [3:0]  be,
    output logic [31:0] st_rep,
    output logic [31:0] ld_data
);

    logic [31:0] b_sh;
    logic [31:0] h_sh;
    logic [7:0]  b;
    logic [15:0] h;

    always_comb begin
        b_sh    = ld_word >> {addr_lo, 3'b000};
        h_sh    = ld_word >> {addr_lo[1], 4'b0000};
        b       = b_sh[7:0];
        h       = h_sh[15:0];
        be      = 4'b1111;
        st_rep  = st_data;
        ld_data = ld_word;
        // size[2] marks the unsigned load variants
        case (size[1:0])
            2'b00: begin
                be      = 4'b0001 << addr_lo;
                st_rep  = {4{st_data[7:0]}};
                ld_data = size[2] ? {24'b0, b} : {{24{b[7]}}, b};
            end
            2'b01: begin
                be      = 4'b0011 << {addr_lo[1], 1'b0};
                st_rep  = {2{st_data[15:0]}};
                ld_data = size[2] ? {16'b0, h} : {{16{h[15]}}, h};
            end
            default: begin
                be      = 4'b1111;
                st_rep  = st_data;
                ld_data = ld_word;
            end
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store unit: req/gnt/rvalid bus master with stall and timeout.
// Define LSU_MISALIGN_TRAP_EN to fault misaligned H/W accesses without a bus cycle.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [2:0]  req_size,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        lsu_busy,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    input  logic        mem_err
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    lsu_state_t  state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [2:0]  size_q, size_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic [3:0]  be;
    logic [31:0] st_rep;
    logic [31:0] ld_data;
    logic        misal;
    logic        bad;

    lsu_align u_align (
        .size    (size_q),
        .addr_lo (addr_q[1:0]),
        .st_data (wdata_q),
        .ld_word (mem_rdata),
        .be      (be),
        .st_rep  (st_rep),
        .ld_data (ld_data)
    );

    always_comb begin
`ifdef LSU_MISALIGN_TRAP_EN
        misal = (req_size[1:0] == 2'b01 && req_addr[0]) ||
                (req_size[1:0] == 2'b10 && req_addr[1:0] != 2'b00);
`else
        misal = 1'b0;
`endif
        bad = !size_legal(req_write, req_size) || misal;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        we_d      = we_q;
        size_d    = size_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        lsu_busy  = 1'b0;
        rsp_valid = 1'b0;
        rsp_rdata = '0;
        rsp_err   = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_be    = '0;
        mem_wdata = '0;
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    lsu_busy = 1'b1;
                    we_d     = req_write;
                    size_d   = req_size;
                    addr_d   = req_addr;
                    wdata_d  = req_wdata;
                    rdata_d  = '0;
                    cnt_d    = '0;
                    err_d    = bad;
                    state_d  = bad ? DONE : REQ;
                end
            end
            REQ: begin
                lsu_busy  = 1'b1;
                mem_req   = 1'b1;
                mem_we    = we_q;
                mem_addr  = {addr_q[31:2], 2'b00};
                mem_be    = be;
                mem_wdata = st_rep;
                cnt_d     = cnt_q + 1'b1;
                // rvalid here is a protocol violation and is dropped
                if (cnt_q == LAST) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end else if (mem_gnt) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                lsu_busy = 1'b1;
                cnt_d    = cnt_q + 1'b1;
                if (mem_rvalid) begin
                    err_d   = mem_err;
                    rdata_d = (mem_err || we_q) ? '0 : ld_data;
                    state_d = DONE;
                end else if (cnt_q == LAST) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                rsp_valid = 1'b1;
                rsp_rdata = rdata_q;
                rsp_err   = err_q;
                state_d   = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            size_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            size_q  <= size_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench: vector table of single accesses plus stall/timeout/reset sequences.
module tb_load_store_unit;
    import load_store_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_valid_to;
    logic        req_write;
    logic [2:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        mem_gnt, mem_rvalid, mem_err;
    logic [31:0] mem_rdata;

    logic        lsu_busy, rsp_valid, rsp_err, mem_req, mem_we;
    logic [31:0] rsp_rdata, mem_addr, mem_wdata;
    logic [3:0]  mem_be;

    logic        t_busy, t_rsp_valid, t_rsp_err, t_mem_req, t_mem_we;
    logic [31:0] t_rsp_rdata, t_mem_addr, t_mem_wdata;
    logic [3:0]  t_mem_be;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    load_store_unit dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_write(req_write), .req_size(req_size),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .lsu_busy(lsu_busy), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .mem_err(mem_err)
    );

    load_store_unit #(.TIMEOUT_CYCLES(4)) dut_to (
        .clk(clk), .rst(rst),
        .req_valid(req_valid_to), .req_write(req_write), .req_size(req_size),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .lsu_busy(t_busy), .rsp_valid(t_rsp_valid), .rsp_rdata(t_rsp_rdata),
        .rsp_err(t_rsp_err), .mem_req(t_mem_req), .mem_we(t_mem_we),
        .mem_addr(t_mem_addr), .mem_be(t_mem_be), .mem_wdata(t_mem_wdata),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .mem_err(mem_err)
    );

    typedef struct {
        logic        w;
        logic [2:0]  sz;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] rd;
        logic        berr;
        logic        bus;
        logic [3:0]  be;
        logic [31:0] ewd;
        logic [31:0] erd;
        logic        eerr;
    } vec_t;

    vec_t vecs[15];

    function automatic vec_t mk(logic w, logic [2:0] sz, logic [31:0] a,
                                logic [31:0] wd, logic [31:0] rd, logic berr,
                                logic bus, logic [3:0] be, logic [31:0] ewd,
                                logic [31:0] erd, logic eerr);
        vec_t v;
        v.w = w; v.sz = sz; v.a = a; v.wd = wd; v.rd = rd; v.berr = berr;
        v.bus = bus; v.be = be; v.ewd = ewd; v.erd = erd; v.eerr = eerr;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic issue(input logic w, input logic [2:0] sz, input logic [31:0] a,
                         input logic [31:0] wd);
        req_valid = 1'b1;
        req_write = w;
        req_size  = sz;
        req_addr  = a;
        req_wdata = wd;
    endtask

    task automatic run_vec(input vec_t v, input int i);
        @(negedge clk);
        issue(v.w, v.sz, v.a, v.wd);
        #1;
        chk($sformatf("v%0d_busy_T", i), 32'(lsu_busy), 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        if (v.bus) begin
            chk($sformatf("v%0d_req", i), 32'(mem_req), 32'd1);
            chk($sformatf("v%0d_addr", i), mem_addr, v.a & 32'hFFFF_FFFC);
            chk($sformatf("v%0d_be", i), 32'(mem_be), 32'(v.be));
            chk($sformatf("v%0d_we", i), 32'(mem_we), 32'(v.w));
            chk($sformatf("v%0d_wdata", i), mem_wdata, v.ewd);
            mem_gnt = 1'b1;
            @(negedge clk);
            mem_gnt = 1'b0;
            chk($sformatf("v%0d_req_wait", i), 32'(mem_req), 32'd0);
            chk($sformatf("v%0d_busy_wait", i), 32'(lsu_busy), 32'd1);
            mem_rvalid = 1'b1;
            mem_rdata  = v.rd;
            mem_err    = v.berr;
            @(negedge clk);
            mem_rvalid = 1'b0;
            mem_err    = 1'b0;
        end else begin
            chk($sformatf("v%0d_noreq", i), 32'(mem_req), 32'd0);
        end
        chk($sformatf("v%0d_rsp_valid", i), 32'(rsp_valid), 32'd1);
        chk($sformatf("v%0d_rdata", i), rsp_rdata, v.erd);
        chk($sformatf("v%0d_err", i), 32'(rsp_err), 32'(v.eerr));
        chk($sformatf("v%0d_busy_done", i), 32'(lsu_busy), 32'd0);
        @(negedge clk);
        chk($sformatf("v%0d_rsp_pulse", i), 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        vecs[0]  = mk(0, LW,  32'h100, 0, 32'hDEADBEEF, 0, 1, 4'b1111, 0, 32'hDEADBEEF, 0);
        vecs[1]  = mk(0, LB,  32'h103, 0, 32'h80123456, 0, 1, 4'b1000, 0, 32'hFFFFFF80, 0);
        vecs[2]  = mk(0, LBU, 32'h103, 0, 32'h80123456, 0, 1, 4'b1000, 0, 32'h00000080, 0);
        vecs[3]  = mk(0, LHU, 32'h102, 0, 32'h80123456, 0, 1, 4'b1100, 0, 32'h00008012, 0);
        vecs[4]  = mk(0, LH,  32'h102, 0, 32'h80123456, 0, 1, 4'b1100, 0, 32'hFFFF8012, 0);
        vecs[5]  = mk(0, LH,  32'h100, 0, 32'h80127FFF, 0, 1, 4'b0011, 0, 32'h00007FFF, 0);
        vecs[6]  = mk(1, SB,  32'h201, 32'h000000A5, 0, 0, 1, 4'b0010, 32'hA5A5A5A5, 0, 0);
        vecs[7]  = mk(1, SH,  32'h202, 32'h1234BEEF, 0, 0, 1, 4'b1100, 32'hBEEFBEEF, 0, 0);
        vecs[8]  = mk(1, SW,  32'h204, 32'h12345678, 0, 0, 1, 4'b1111, 32'h12345678, 0, 0);
        vecs[9]  = mk(0, LB,  32'h101, 0, 32'h80123456, 0, 1, 4'b0010, 0, 32'h00000034, 0);
        vecs[10] = mk(0, 3'b011, 32'h100, 0, 0, 0, 0, 0, 0, 0, 1);
        vecs[11] = mk(1, 3'b100, 32'h100, 32'h55, 0, 0, 0, 0, 0, 0, 1);
        vecs[12] = mk(0, LW,  32'h108, 0, 32'h11112222, 1, 1, 4'b1111, 0, 0, 1);
        vecs[13] = mk(0, 3'b110, 32'h100, 0, 0, 0, 0, 0, 0, 0, 1);
`ifdef LSU_MISALIGN_TRAP_EN
        vecs[14] = mk(0, LW, 32'h102, 0, 32'hCAFEF00D, 0, 0, 0, 0, 0, 1);
`else
        vecs[14] = mk(0, LW, 32'h102, 0, 32'hCAFEF00D, 0, 1, 4'b1111, 0, 32'hCAFEF00D, 0);
`endif

        rst = 1'b1;
        req_valid = 0; req_valid_to = 0; req_write = 0; req_size = 0;
        req_addr = 0; req_wdata = 0;
        mem_gnt = 0; mem_rvalid = 0; mem_err = 0; mem_rdata = 0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(lsu_busy), 0);
        chk("rst_req", 32'(mem_req), 0);
        chk("rst_rsp", 32'(rsp_valid), 0);
        chk("rst_addr", mem_addr, 0);
        rst = 1'b0;

        foreach (vecs[i]) run_vec(vecs[i], i);

        // Grant withheld for 5 cycles, then a bus error response
        @(negedge clk);
        issue(0, LW, 32'h300, 0);
        @(negedge clk);
        req_valid = 1'b0;
        for (int k = 0; k < 6; k++) begin
            chk($sformatf("stall%0d_req", k), 32'(mem_req), 1);
            chk($sformatf("stall%0d_addr", k), mem_addr, 32'h300);
            chk($sformatf("stall%0d_be", k), 32'(mem_be), 32'hF);
            chk($sformatf("stall%0d_busy", k), 32'(lsu_busy), 1);
            if (k == 5) mem_gnt = 1'b1;
            @(negedge clk);
        end
        mem_gnt = 1'b0;
        mem_rvalid = 1'b1; mem_err = 1'b1; mem_rdata = 32'h5555AAAA;
        @(negedge clk);
        mem_rvalid = 1'b0; mem_err = 1'b0;
        chk("stall_rsp", 32'(rsp_valid), 1);
        chk("stall_err", 32'(rsp_err), 1);
        chk("stall_rdata", rsp_rdata, 0);

        // Timeout on the TIMEOUT_CYCLES=4 instance, no grant ever
        @(negedge clk);
        req_valid_to = 1'b1; req_write = 0; req_size = LW; req_addr = 32'h100;
        @(negedge clk);
        req_valid_to = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("to%0d_rsp", k), 32'(t_rsp_valid), 0);
            chk($sformatf("to%0d_busy", k), 32'(t_busy), 1);
            @(negedge clk);
        end
        chk("to_rsp", 32'(t_rsp_valid), 1);
        chk("to_err", 32'(t_rsp_err), 1);
        chk("to_req_drop", 32'(t_mem_req), 0);
        @(negedge clk);

        // req_valid held through DONE is not accepted there
        issue(0, 3'b111, 32'h0, 0);
        @(negedge clk);
        req_size = LW;
        chk("done_busy", 32'(lsu_busy), 0);
        chk("done_rsp", 32'(rsp_valid), 1);
        @(negedge clk);
        chk("done_idle_noreq", 32'(mem_req), 0);
        chk("done_idle_busy", 32'(lsu_busy), 1);
        @(negedge clk);
        req_valid = 1'b0;
        chk("done_next_req", 32'(mem_req), 1);

        // Reset in WAIT aborts; a stale rvalid afterwards is ignored
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        chk("wait_busy", 32'(lsu_busy), 1);
        rst = 1'b1;
        #1;
        chk("rstw_busy", 32'(lsu_busy), 0);
        chk("rstw_rsp", 32'(rsp_valid), 0);
        chk("rstw_req", 32'(mem_req), 0);
        @(negedge clk);
        rst = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = 32'hFFFFFFFF;
        @(negedge clk);
        mem_rvalid = 1'b0;
        chk("stale_rsp0", 32'(rsp_valid), 0);
        @(negedge clk);
        chk("stale_rsp1", 32'(rsp_valid), 0);
        chk("stale_busy", 32'(lsu_busy), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
